// File: rtl/cla_add_sub4.sv
// 4-bit carry-lookahead adder/subtractor with registered result, carry, overflow and group flags.
// Define CLA_ADD_SUB4_GP_EN to compute and register group generate/propagate; otherwise g and p stay 0.
module cla_add_sub4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       sub,
    input  logic       cin,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       out_valid,
    output logic [3:0] out,
    output logic       cout,
    output logic       v,
    output logic       g,
    output logic       p
);

    localparam int unsigned W = 4;

    logic [W-1:0] w_yb;
    logic         w_c0;
    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;
    logic [W-1:0] w_s;
    logic         w_grp_g;
    logic         w_grp_p;

    logic         r_valid;
    logic [W-1:0] r_out;
    logic         r_cout;
    logic         r_v;
    logic         r_g;
    logic         r_p;

    // Subtract is x + ~y + 1; a borrow-in removes the +1.
    assign w_yb = y ^ {W{sub}};
    assign w_c0 = cin ^ sub;
    assign w_g  = x & w_yb;
    assign w_p  = x ^ w_yb;

    // Flattened lookahead: every carry depends only on g, p and c0.
    always_comb begin
        w_c    = '0;
        w_c[0] = w_c0;
        w_c[1] = w_g[0] | (w_p[0] & w_c0);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c0);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_c0);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c0);
    end

    assign w_s = w_p ^ w_c[W-1:0];

`ifdef CLA_ADD_SUB4_GP_EN
    assign w_grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign w_grp_p = &w_p;
`else
    assign w_grp_g = 1'b0;
    assign w_grp_p = 1'b0;
`endif

    // Results load only on valid input; otherwise they hold and out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
            r_g     <= 1'b0;
            r_p     <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out  <= w_s;
                r_cout <= w_c[W];
                r_v    <= w_c[W] ^ w_c[W-1];
                r_g    <= w_grp_g;
                r_p    <= w_grp_p;
            end
        end
    end

    assign out_valid = r_valid;
    assign out       = r_out;
    assign cout      = r_cout;
    assign v         = r_v;
    assign g         = r_g;
    assign p         = r_p;

endmodule

// File: tb/tb_cla_add_sub4.sv
// Directed and exhaustive checks for cla_add_sub4: vector table, sweeps, hold and async reset.
module tb_cla_add_sub4;

    typedef struct {
        logic       sub;
        logic       cin;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] out;
        logic       cout;
        logic       v;
        logic       g;
        logic       p;
    } vec_t;

`ifdef CLA_ADD_SUB4_GP_EN
    localparam bit GP_EN = 1'b1;
`else
    localparam bit GP_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       sub;
    logic       cin;
    logic [3:0] x;
    logic [3:0] y;
    logic       out_valid;
    logic [3:0] out;
    logic       cout;
    logic       v;
    logic       g;
    logic       p;

    int n_vec;
    int n_err;

    cla_add_sub4 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub), .cin(cin),
        .x(x), .y(y), .out_valid(out_valid), .out(out), .cout(cout),
        .v(v), .g(g), .p(p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] actual();
        return {out_valid, out, cout, v, g, p};
    endfunction

    // Arithmetic reference: {valid, out, cout, v, g, p}.
    function automatic logic [8:0] model(input logic s, input logic ci,
                                         input logic [3:0] a, input logic [3:0] b);
        logic [3:0] yb;
        logic       c0;
        logic [4:0] sum;
        logic [3:0] lo;
        logic [4:0] nc;
        logic       gg;
        logic       pp;
        yb  = b ^ {4{s}};
        c0  = ci ^ s;
        sum = {1'b0, a} + {1'b0, yb} + 5'(c0);
        lo  = {1'b0, a[2:0]} + {1'b0, yb[2:0]} + 4'(c0);
        nc  = {1'b0, a} + {1'b0, yb};
        gg  = GP_EN & nc[4];
        pp  = GP_EN & ((a ^ yb) == 4'hF);
        return {1'b1, sum[3:0], sum[4], sum[4] ^ lo[3], gg, pp};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = actual();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {vld,out,cout,v,g,p}=%b_%h_%b%b%b%b expected %b_%h_%b%b%b%b",
                     name, act[8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic s, input logic ci, input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1;
        sub      = s;
        cin      = ci;
        x        = a;
        y        = b;
    endtask

    vec_t       tbl[8];
    logic [8:0] exp_r;
    logic [8:0] last;

    initial begin
        n_vec = 0;
        n_err = 0;
        // Hand-computed expectations; g/p columns are for the GP-enabled build.
        tbl[0] = '{sub:1'b0, cin:1'b1, x:4'hF, y:4'h0, out:4'h0, cout:1'b1, v:1'b0, g:1'b0, p:1'b1};
        tbl[1] = '{sub:1'b1, cin:1'b0, x:4'h7, y:4'hF, out:4'h8, cout:1'b0, v:1'b1, g:1'b0, p:1'b0};
        tbl[2] = '{sub:1'b1, cin:1'b0, x:4'h8, y:4'h1, out:4'h7, cout:1'b1, v:1'b1, g:1'b1, p:1'b0};
        tbl[3] = '{sub:1'b0, cin:1'b0, x:4'h5, y:4'h3, out:4'h8, cout:1'b0, v:1'b1, g:1'b0, p:1'b0};
        tbl[4] = '{sub:1'b0, cin:1'b0, x:4'hA, y:4'h5, out:4'hF, cout:1'b0, v:1'b0, g:1'b0, p:1'b1};
        tbl[5] = '{sub:1'b1, cin:1'b1, x:4'h4, y:4'h1, out:4'h2, cout:1'b1, v:1'b0, g:1'b1, p:1'b0};
        tbl[6] = '{sub:1'b0, cin:1'b0, x:4'h1, y:4'h1, out:4'h2, cout:1'b0, v:1'b0, g:1'b0, p:1'b0};
        tbl[7] = '{sub:1'b1, cin:1'b0, x:4'h0, y:4'h0, out:4'h0, cout:1'b1, v:1'b0, g:1'b0, p:1'b1};

        rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; cin = 1'b0; x = '0; y = '0;
        #12;
        check("reset_state", 9'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table vectors, mode changing every cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(tbl[i].sub, tbl[i].cin, tbl[i].x, tbl[i].y);
            @(posedge clk);
            #1;
            exp_r = {1'b1, tbl[i].out, tbl[i].cout, tbl[i].v, GP_EN & tbl[i].g, GP_EN & tbl[i].p};
            check($sformatf("table_%0d", i), exp_r);
        end

        // Exhaustive add with carry-in and subtract without borrow.
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                drive(1'(m), 1'(1 - m), 4'(k >> 4), 4'(k));
                @(posedge clk);
                #1;
                exp_r = model(1'(m), 1'(1 - m), 4'(k >> 4), 4'(k));
                check(m == 0 ? "sweep_add" : "sweep_sub", exp_r);
            end
        end

        // Dropping in_valid clears out_valid and holds the last result.
        last = exp_r;
        @(negedge clk);
        in_valid = 1'b0; x = 4'h3; y = 4'h9; sub = 1'b0;
        @(posedge clk);
        #1;
        check("hold", {1'b0, last[7:0]});
        @(posedge clk);
        #1;
        check("hold_2", {1'b0, last[7:0]});

        // Async reset between edges discards the pending result.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'h9, 4'h9);
        @(posedge clk);
        #1;
        check("pre_reset", model(1'b0, 1'b1, 4'h9, 4'h9));
        @(negedge clk);
        drive(1'b1, 1'b0, 4'h6, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 9'b0);
        @(posedge clk);
        #1;
        check("reset_held", 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'h1, 4'h1);
        #1;
        check("post_release", 9'b0);
        @(posedge clk);
        #1;
        check("first_after_reset", {1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
